t_ff_count_ctrl: RTL

Sequencing controller for a WIDTH-bit bank of toggle (T) flip-flop cells. It computes a per-bit toggle vector each cycle and applies it to the cell bank, giving up-count, down-count and direct-load operations bounded by a programmable terminal value. It sits between a host-side start/stop handshake and the T-cell bank, and exposes both the bank state and the applied toggle vector for observation.

---
 rtl/t_ff_count_ctrl.sv | 116 +++++++++++
 1 files changed

// File: rtl/t_ff_count_ctrl.sv
// Sequencing controller for a WIDTH-bit toggle flip-flop bank: up/down count to a terminal value, or direct load.
// Optional feature: define TFF_CTRL_PAUSE_EN to add a `pause` input that freezes counting in RUN.
module t_ff_count_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] load_val,
    input  logic [WIDTH-1:0] term,
    input  logic             stop,
`ifdef TFF_CTRL_PAUSE_EN
    input  logic             pause,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] t_vec
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        LOAD = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] t_next;
    logic [WIDTH-1:0] term_q;
    logic             count_down_q;
    logic [WIDTH-1:0] up_vec;
    logic [WIDTH-1:0] down_vec;
    logic             hold_run;

`ifdef TFF_CTRL_PAUSE_EN
    assign hold_run = pause;
`else
    assign hold_run = 1'b0;
`endif

    // A bit toggles when every lower bit is 1 (counting up) or 0 (counting down).
    always_comb begin
        logic up_carry;
        logic down_borrow;
        up_carry    = 1'b1;
        down_borrow = 1'b1;
        up_vec      = '0;
        down_vec    = '0;
        for (int i = 0; i < WIDTH; i++) begin
            up_vec[i]   = up_carry;
            down_vec[i] = down_borrow;
            up_carry    = up_carry & q[i];
            down_borrow = down_borrow & ~q[i];
        end
    end

    always_comb begin
        state_next = state;
        t_next     = '0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = mode[1] ? LOAD : RUN;
                end
            end
            RUN: begin
                if (stop) begin
                    state_next = IDLE;
                end else if (hold_run) begin
                    state_next = RUN;
                end else if (q == term_q) begin
                    state_next = DONE;
                end else begin
                    t_next = count_down_q ? down_vec : up_vec;
                end
            end
            LOAD: begin
                t_next     = q ^ load_val;
                state_next = DONE;
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // busy/done are registered from the next state so they track the state register exactly.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            q            <= '0;
            t_vec        <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            term_q       <= '0;
            count_down_q <= 1'b0;
        end else begin
            state <= state_next;
            q     <= q ^ t_next;
            t_vec <= t_next;
            busy  <= (state_next == RUN) || (state_next == LOAD);
            done  <= (state_next == DONE);
            if (state == IDLE && start) begin
                term_q       <= term;
                count_down_q <= mode[0];
            end
        end
    end

endmodule
